// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-port SRAM arbiter.
package sram_arb_pkg;
    typedef enum logic {OWN_M0 = 1'b0, OWN_M1 = 1'b1} owner_e;

    localparam int DEF_AW   = 32;
    localparam int DEF_DW   = 32;
    // Wide enough for MAX_BURST up to 15.
    localparam int BURST_CW = 4;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of fetch port (m0), data port (m1) and SRAM-side signals around the arbiter.
// slave = arbiter view; master = requesters plus SRAM model view.
interface sram_port_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          m0_req;
    logic [AW-1:0] m0_addr;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          sram_req;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    modport slave (
        input  m0_req, m0_addr,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  sram_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output sram_req, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output m0_req, m0_addr,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output sram_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  sram_req, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Fetch/data arbiter for one single-port SRAM: combinational grant, read data one cycle later;
// losers are backpressured by holding gnt low. SRAM_ARB_RR_EN selects round-robin over fixed priority.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    sram_port_arbiter_if.slave bus
);
    logic          gnt_m0;
    logic          gnt_m1;
    logic          m0_rvalid_q;
    logic          m1_rvalid_q;
    logic [DW-1:0] m0_rdata_q;
    logic [DW-1:0] m1_rdata_q;

`ifdef SRAM_ARB_RR_EN
    // Owner history only matters for the round-robin tie-break.
    owner_e last_owner;

    always_comb begin
        gnt_m0 = 1'b0;
        gnt_m1 = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            gnt_m1 = (last_owner == OWN_M0);
            gnt_m0 = !gnt_m1;
        end else begin
            gnt_m0 = bus.m0_req;
            gnt_m1 = bus.m1_req;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_owner <= OWN_M0;
        end else if (gnt_m0) begin
            last_owner <= OWN_M0;
        end else if (gnt_m1) begin
            last_owner <= OWN_M1;
        end
    end
`else
    localparam logic [BURST_CW-1:0] BURST_MAX = BURST_CW'(MAX_BURST);

    logic [BURST_CW-1:0] burst_cnt;
    logic [BURST_CW-1:0] burst_cnt_nxt;
    logic                starve;

    // Data port wins unless fetch has already watched MAX_BURST data grants go by.
    always_comb begin
        starve        = bus.m0_req && (burst_cnt == BURST_MAX);
        gnt_m1        = bus.m1_req && !starve;
        gnt_m0        = bus.m0_req && !gnt_m1;
        burst_cnt_nxt = burst_cnt;
        if (!bus.m0_req || gnt_m0) begin
            burst_cnt_nxt = '0;
        end else if (gnt_m1 && (burst_cnt != BURST_MAX)) begin
            burst_cnt_nxt = burst_cnt + BURST_CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            burst_cnt <= '0;
        end else begin
            burst_cnt <= burst_cnt_nxt;
        end
    end
`endif

    always_comb begin
        bus.sram_req   = gnt_m0 | gnt_m1;
        bus.sram_we    = gnt_m1 & bus.m1_we;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        if (gnt_m0) begin
            bus.sram_addr = bus.m0_addr;
        end else if (gnt_m1) begin
            bus.sram_addr  = bus.m1_addr;
            bus.sram_wdata = bus.m1_wdata;
        end
    end

    // Read data is sampled at the grant edge; writes never produce a response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            m0_rvalid_q <= gnt_m0;
            m1_rvalid_q <= gnt_m1 && !bus.m1_we;
            if (gnt_m0) begin
                m0_rdata_q <= bus.sram_rdata;
            end
            if (gnt_m1 && !bus.m1_we) begin
                m1_rdata_q <= bus.sram_rdata;
            end
        end
    end

    assign bus.m0_gnt    = gnt_m0;
    assign bus.m1_gnt    = gnt_m1;
    assign bus.m0_rvalid = m0_rvalid_q;
    assign bus.m0_rdata  = m0_rdata_q;
    assign bus.m1_rvalid = m1_rvalid_q;
    assign bus.m1_rdata  = m1_rdata_q;
endmodule
